// File: rtl/change_dispenser_if.sv
// Payout request and coin-eject bundle between the machine controller and the change dispenser.
// The controller is the master and the dispenser is the slave.
interface change_dispenser_if #(
  parameter int unsigned AMT_W = 8,
  parameter int unsigned CNT_W = 6
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             refill;
  logic             pay_Q;
  logic             pay_D;
  logic             pay_N;
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] inv_Q;
  logic [CNT_W-1:0] inv_D;
  logic [CNT_W-1:0] inv_N;

  modport master (
    output start, amount, refill,
    input  pay_Q, pay_D, pay_N, busy, done, short, remaining, inv_Q, inv_D, inv_N
  );

  modport slave (
    input  start, amount, refill,
    output pay_Q, pay_D, pay_N, busy, done, short, remaining, inv_Q, inv_D, inv_N
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-change payout engine: pays out an amount given in nickel units as one-cycle
// quarter/dime/nickel eject pulses, and tracks the inventory of each coin hopper.
module change_dispenser #(
  parameter int unsigned AMT_W  = 8,
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned INIT_Q = 20,
  parameter int unsigned INIT_D = 20,
  parameter int unsigned INIT_N = 20,
  parameter int unsigned GAP    = 1
) (
  input logic              clk,
  input logic              reset,
  change_dispenser_if.slave bus
);

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GapW-1:0] GapInit = GapW'(GAP);

  typedef enum logic [1:0] {StIdle, StSel, StPulse, StGap} state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic [CNT_W-1:0] n_cnt_q, n_cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [2:0]       eject_q, eject_d;  // {quarter, dime, nickel}
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q, short_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_cnt_d = q_cnt_q;
    d_cnt_d = d_cnt_q;
    n_cnt_d = n_cnt_q;
    gap_d   = gap_q;
    eject_d = 3'b000;
    busy_d  = busy_q;
    done_d  = 1'b0;
    short_d = short_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          rem_d   = bus.amount;
          busy_d  = 1'b1;
          short_d = 1'b0;
          state_d = StSel;
        end
      end
      StSel: begin
        // Largest coin first; an empty hopper falls through to the next denomination.
        if (rem_q >= AMT_W'(5) && q_cnt_q != '0) begin
          eject_d = 3'b100;
          rem_d   = rem_q - AMT_W'(5);
          q_cnt_d = q_cnt_q - CNT_W'(1);
          state_d = StPulse;
        end else if (rem_q >= AMT_W'(2) && d_cnt_q != '0) begin
          eject_d = 3'b010;
          rem_d   = rem_q - AMT_W'(2);
          d_cnt_d = d_cnt_q - CNT_W'(1);
          state_d = StPulse;
        end else if (rem_q >= AMT_W'(1) && n_cnt_q != '0) begin
          eject_d = 3'b001;
          rem_d   = rem_q - AMT_W'(1);
          n_cnt_d = n_cnt_q - CNT_W'(1);
          state_d = StPulse;
        end else begin
          done_d  = 1'b1;
          short_d = (rem_q != '0);
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StPulse: begin
        gap_d   = GapInit;
        state_d = StGap;
      end
      StGap: begin
        if (gap_q <= GapW'(1)) begin
          state_d = StSel;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Refill overrides any decrement made in the same cycle.
    if (bus.refill) begin
      q_cnt_d = CNT_W'(INIT_Q);
      d_cnt_d = CNT_W'(INIT_D);
      n_cnt_d = CNT_W'(INIT_N);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      q_cnt_q <= CNT_W'(INIT_Q);
      d_cnt_q <= CNT_W'(INIT_D);
      n_cnt_q <= CNT_W'(INIT_N);
      gap_q   <= '0;
      eject_q <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_cnt_q <= q_cnt_d;
      d_cnt_q <= d_cnt_d;
      n_cnt_q <= n_cnt_d;
      gap_q   <= gap_d;
      eject_q <= eject_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      short_q <= short_d;
    end
  end

  assign bus.pay_Q     = eject_q[2];
  assign bus.pay_D     = eject_q[1];
  assign bus.pay_N     = eject_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.short     = short_q;
  assign bus.remaining = rem_q;
  assign bus.inv_Q     = q_cnt_q;
  assign bus.inv_D     = d_cnt_q;
  assign bus.inv_N     = n_cnt_q;

endmodule
